// File: rtl/vc_fifo_pkg.sv
// vc_fifo_pkg: shared sizing helpers for the virtual-channel FIFO bank.
//   clog2()   - ceiling log2 used to size VC index fields
//   vcw()     - VC index width, at least 1 bit
//   thr_w()   - width of one packed threshold slice (LEN+1)
//   thr_lsb() - LSB of VC i's slice inside a packed threshold bus
package vc_fifo_pkg;

    localparam int BW_DEF     = 6;
    localparam int LEN_DEF    = 2;
    localparam int NUM_VC_DEF = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) r++;
        return r;
    endfunction

    function automatic int vcw(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

    function automatic int thr_w(input int len);
        return len + 1;
    endfunction

    function automatic int thr_lsb(input int vc, input int len);
        return vc * (len + 1);
    endfunction

endpackage

// File: rtl/vc_fifo_bank_if.sv
// vc_fifo_bank_if: push/pop bus of the VC FIFO bank.
//   master modport (producer/consumer side): drives wr, wr_vc, data_in, rd,
//     umbral_bajo, umbral_alto; observes data_out, data_out_vc,
//     data_out_valid and the per-VC full/empty/almost/error flags.
//   slave modport (vc_fifo_bank side): the mirror image.
interface vc_fifo_bank_if import vc_fifo_pkg::*; #(
    parameter int BW     = BW_DEF,
    parameter int LEN    = LEN_DEF,
    parameter int NUM_VC = NUM_VC_DEF
);
    localparam int VCW = vcw(NUM_VC);
    localparam int TW  = thr_w(LEN);

    logic                   wr;
    logic [VCW-1:0]         wr_vc;
    logic [BW-1:0]          data_in;
    logic                   rd;
    logic [NUM_VC*TW-1:0]   umbral_bajo;
    logic [NUM_VC*TW-1:0]   umbral_alto;
    logic [BW-1:0]          data_out;
    logic [VCW-1:0]         data_out_vc;
    logic                   data_out_valid;
    logic [NUM_VC-1:0]      full;
    logic [NUM_VC-1:0]      empty;
    logic [NUM_VC-1:0]      almost_full;
    logic [NUM_VC-1:0]      almost_empty;
    logic [NUM_VC-1:0]      error_output;

    modport master (
        output wr, wr_vc, data_in, rd, umbral_bajo, umbral_alto,
        input  data_out, data_out_vc, data_out_valid,
               full, empty, almost_full, almost_empty, error_output
    );

    modport slave (
        input  wr, wr_vc, data_in, rd, umbral_bajo, umbral_alto,
        output data_out, data_out_vc, data_out_valid,
               full, empty, almost_full, almost_empty, error_output
    );

endinterface

// File: rtl/vc_fifo_ch.sv
// vc_fifo_ch: one virtual-channel FIFO of DEPTH=2**LEN words.
//   clk, reset_L   clock / async active-low reset
//   push_i         write request addressed to this VC
//   pop_i          arbiter grant; ignored when empty
//   data_i         push data
//   thr_lo_i/hi_i  live low/high occupancy thresholds
//   head_o         word at the read pointer
//   full_o/empty_o occupancy == DEPTH / == 0
//   afull_o        count >= thr_hi_i
//   aempty_o       count <= thr_lo_i
//   err_o          sticky: a push was dropped because the VC was full
module vc_fifo_ch import vc_fifo_pkg::*; #(
    parameter int BW  = BW_DEF,
    parameter int LEN = LEN_DEF
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [BW-1:0] data_i,
    input  logic [LEN:0]  thr_lo_i,
    input  logic [LEN:0]  thr_hi_i,
    output logic [BW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          afull_o,
    output logic          aempty_o,
    output logic          err_o
);
    localparam int DEPTH = 1 << LEN;

    logic [BW-1:0]  mem_q [DEPTH];
    logic [LEN-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [LEN:0]   cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           do_pop, acc;

    assign do_pop = pop_i && !empty_o;
    // A full VC still accepts a push when it pops in the same cycle.
    assign acc    = push_i && (!full_o || do_pop);

    always_comb begin
        wp_d  = acc    ? wp_q + 1'b1 : wp_q;
        rp_d  = do_pop ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q + {{LEN{1'b0}}, acc} - {{LEN{1'b0}}, do_pop};
        err_d = err_q | (push_i && !acc);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (acc) mem_q[wp_q] <= data_i;
    end

    assign head_o   = mem_q[rp_q];
    assign full_o   = cnt_q == (LEN+1)'(DEPTH);
    assign empty_o  = cnt_q == '0;
    assign afull_o  = cnt_q >= thr_hi_i;
    assign aempty_o = cnt_q <= thr_lo_i;
    assign err_o    = err_q;

endmodule

// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: NUM_VC independent VC FIFOs behind one shared push port and
// one arbitrated, registered pop port.
//   clk      single clock, rising edge
//   reset_L  asynchronous active-low reset
//   bus      vc_fifo_bank_if.slave: push (wr/wr_vc/data_in), pop ready (rd),
//            packed thresholds, registered pop output and per-VC flags
// Build option VC_RR_ARB_EN: round-robin pop arbitration with a last-grant
// pointer; otherwise strict priority with the highest VC index winning.
module vc_fifo_bank import vc_fifo_pkg::*; #(
    parameter int BW     = BW_DEF,
    parameter int LEN    = LEN_DEF,
    parameter int NUM_VC = NUM_VC_DEF
) (
    input logic           clk,
    input logic           reset_L,
    vc_fifo_bank_if.slave bus
);
    localparam int VCW = vcw(NUM_VC);
    localparam int TW  = thr_w(LEN);

    logic [BW-1:0]     head [NUM_VC];
    logic [NUM_VC-1:0] full_v, empty_v, afull_v, aempty_v, err_v;
    logic [VCW-1:0]    grant_vc;
    logic              grant_any, pop_any;
    logic [BW-1:0]     data_q, data_d;
    logic [VCW-1:0]    vc_q, vc_d;
    logic              valid_q, valid_d;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_ch
        vc_fifo_ch #(.BW(BW), .LEN(LEN)) u_ch (
            .clk      (clk),
            .reset_L  (reset_L),
            .push_i   (bus.wr && (bus.wr_vc == VCW'(g))),
            .pop_i    (pop_any && (grant_vc == VCW'(g))),
            .data_i   (bus.data_in),
            .thr_lo_i (bus.umbral_bajo[thr_lsb(g, LEN) +: TW]),
            .thr_hi_i (bus.umbral_alto[thr_lsb(g, LEN) +: TW]),
            .head_o   (head[g]),
            .full_o   (full_v[g]),
            .empty_o  (empty_v[g]),
            .afull_o  (afull_v[g]),
            .aempty_o (aempty_v[g]),
            .err_o    (err_v[g])
        );
    end

`ifdef VC_RR_ARB_EN
    logic [VCW-1:0] last_q, last_d;

    // Search begins one past the last granted VC; first non-empty VC wins.
    always_comb begin
        int idx;
        grant_vc  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_VC; k++) begin
            idx = (int'(last_q) + k) % NUM_VC;
            if (!grant_any && !empty_v[idx]) begin
                grant_any = 1'b1;
                grant_vc  = VCW'(idx);
            end
        end
        last_d = pop_any ? grant_vc : last_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) last_q <= '0;
        else          last_q <= last_d;
    end
`else
    // Ascending scan: the last non-empty VC seen (highest index) wins.
    always_comb begin
        grant_vc  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_VC; k++) begin
            if (!empty_v[k]) begin
                grant_any = 1'b1;
                grant_vc  = VCW'(k);
            end
        end
    end
`endif

    assign pop_any = bus.rd && grant_any;

    always_comb begin
        data_d  = pop_any ? head[grant_vc] : data_q;
        vc_d    = pop_any ? grant_vc : vc_q;
        valid_d = pop_any;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_q  <= '0;
            vc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            vc_q    <= vc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.data_out       = data_q;
    assign bus.data_out_vc    = vc_q;
    assign bus.data_out_valid = valid_q;
    assign bus.full           = full_v;
    assign bus.empty          = empty_v;
    assign bus.almost_full    = afull_v;
    assign bus.almost_empty   = aempty_v;
    assign bus.error_output   = err_v;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// tb_vc_fifo_bank: directed stimulus with a scoreboard queue of expected
// {vc,data} pops, checked by an independent monitor, plus flag checks.
module tb_vc_fifo_bank;
    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    vc_fifo_bank_if #(.BW(6), .LEN(2), .NUM_VC(2)) bus();
    vc_fifo_bank #(.BW(6), .LEN(2), .NUM_VC(2)) dut (
        .clk(clk), .reset_L(reset_L), .bus(bus)
    );

    int total = 0;
    int bad = 0;
    logic [6:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset_L && bus.data_out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got vc=%0d data=%0h want no pop",
                         bus.data_out_vc, bus.data_out);
            end else begin
                chk("pop", {25'd0, bus.data_out_vc, bus.data_out}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc(input logic w, input logic vc, input logic [5:0] d, input logic r);
        bus.wr = w; bus.wr_vc = vc; bus.data_in = d; bus.rd = r;
        @(posedge clk); #1;
        bus.wr = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic pop_exp(input logic vc, input logic [5:0] d);
        exp_q.push_back({vc, d});
        cyc(1'b0, 1'b0, 6'h0, 1'b1);
    endtask

    initial begin
        bus.wr = 1'b0; bus.wr_vc = 1'b0; bus.data_in = '0; bus.rd = 1'b0;
        bus.umbral_alto = {3'd4, 3'd3};
        bus.umbral_bajo = {3'd0, 3'd0};
        #2;
        chk("rst_empty", bus.empty, 2'b11);
        chk("rst_full", bus.full, 2'b00);
        chk("rst_valid", bus.data_out_valid, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_vc", bus.data_out_vc, 0);
        chk("rst_err", bus.error_output, 2'b00);
        chk("rst_aempty", bus.almost_empty, 2'b11);
        repeat (2) @(posedge clk);
        #1 reset_L = 1'b1;
        // 1: three words into VC0
        cyc(1, 0, 6'h11, 0); cyc(1, 0, 6'h12, 0); cyc(1, 0, 6'h13, 0);
        chk("t1_empty", bus.empty, 2'b10);
        chk("t1_afull", bus.almost_full, 2'b01);
        chk("t1_full", bus.full, 2'b00);
        chk("t1_aempty", bus.almost_empty, 2'b10);
        bus.umbral_bajo = {3'd0, 3'd3};
        #1 chk("t1_live_thr", bus.almost_empty, 2'b11);
        bus.umbral_bajo = {3'd0, 3'd0};
        pop_exp(0, 6'h11); pop_exp(0, 6'h12); pop_exp(0, 6'h13);
        chk("t1_drained", bus.empty, 2'b11);
        // 2: A in VC0, B in VC1
        cyc(1, 0, 6'h0A, 0); cyc(1, 1, 6'h0B, 0);
        pop_exp(1, 6'h0B); pop_exp(0, 6'h0A);
        cyc(1, 0, 6'h21, 0); cyc(1, 1, 6'h31, 0); cyc(1, 1, 6'h32, 0);
`ifdef VC_RR_ARB_EN
        pop_exp(1, 6'h31); pop_exp(0, 6'h21); pop_exp(1, 6'h32);
`else
        pop_exp(1, 6'h31); pop_exp(1, 6'h32); pop_exp(0, 6'h21);
`endif
        // 3: overflow VC1
        for (int i = 0; i < 4; i++) cyc(1, 1, 6'h24 + 6'(i), 0);
        chk("t3_full", bus.full, 2'b10);
        chk("t3_err_before", bus.error_output, 2'b00);
        cyc(1, 1, 6'h2A, 0);
        chk("t3_err", bus.error_output, 2'b10);
        for (int i = 0; i < 4; i++) pop_exp(1, 6'h24 + 6'(i));
        chk("t3_err_sticky", bus.error_output, 2'b10);
        chk("t3_empty", bus.empty, 2'b11);
        // 4: push into full VC0 while it pops
        for (int i = 1; i <= 4; i++) cyc(1, 0, 6'(i), 0);
        chk("t4_full", bus.full, 2'b01);
        exp_q.push_back({1'b0, 6'h01});
        cyc(1, 0, 6'h05, 1);
        chk("t4_full_kept", bus.full, 2'b01);
        chk("t4_err", bus.error_output, 2'b10);
        for (int i = 2; i <= 5; i++) pop_exp(0, 6'(i));
        chk("t4_empty", bus.empty, 2'b11);
        // 5: rd with everything empty
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 6'h0, 1);
            chk("t5_valid", bus.data_out_valid, 0);
        end
        chk("t5_err", bus.error_output, 2'b10);
        // 6: async reset with a pulse in flight
        cyc(1, 1, 6'h3C, 0);
        cyc(0, 0, 6'h0, 1);
        chk("t6_valid_pre", bus.data_out_valid, 1);
        chk("t6_data_pre", bus.data_out, 6'h3C);
        #1 reset_L = 1'b0;
        #1;
        chk("t6_valid", bus.data_out_valid, 0);
        chk("t6_data", bus.data_out, 0);
        chk("t6_vc", bus.data_out_vc, 0);
        chk("t6_err", bus.error_output, 2'b00);
        chk("t6_empty", bus.empty, 2'b11);
        @(posedge clk); #1 reset_L = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
